// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: DRP widths, responder FSM states and MMCM register addresses. Rev 1.0.
`default_nettype none

package mmcm_drp_pkg;
   localparam int DRP_ADDR_W = 7;
   localparam int DRP_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } drp_state_t;

   localparam logic [DRP_ADDR_W-1:0] CLKOUT0_REG1  = 7'h08;
   localparam logic [DRP_ADDR_W-1:0] CLKOUT0_REG2  = 7'h09;
   localparam logic [DRP_ADDR_W-1:0] DIVCLK        = 7'h16;
   localparam logic [DRP_ADDR_W-1:0] CLKFBOUT_REG1 = 7'h14;
   localparam logic [DRP_ADDR_W-1:0] POWER         = 7'h28;
endpackage

`default_nettype wire

// File: rtl/mmcm_drp_lock_model.sv
// mmcm_drp_lock_model: locked rises LOCK_DELAY cycles after rst_mmcm is released. Rev 1.0.
`default_nettype none

module mmcm_drp_lock_model #(
   parameter int LOCK_DELAY = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rst_mmcm,
   output logic locked
);
   localparam int            CW   = $clog2(LOCK_DELAY + 1);
   localparam logic [CW-1:0] FULL = CW'(LOCK_DELAY);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         locked <= 1'b0;
      end else if (rst_mmcm) begin
         cnt    <= '0;
         locked <= 1'b0;
      end else if (cnt != FULL) begin
         // Saturating count; locked follows the count reaching FULL.
         cnt    <= cnt + CW'(1);
         locked <= ((cnt + CW'(1)) == FULL);
      end
   end
endmodule

`default_nettype wire

// File: rtl/mmcm_drp_responder.sv
// mmcm_drp_responder: 128x16 DRP register file with fixed-latency drdy and a lock model. Rev 1.0.
// Optional MMCM_DRP_WRLOCK_EN: writes while rst_mmcm=0 are dropped and flagged in proto_err.
`default_nettype none

module mmcm_drp_responder
   import mmcm_drp_pkg::*;
#(
   parameter int              RD_LATENCY = 3,
   parameter int              WR_LATENCY = 3,
   parameter int              LOCK_DELAY = 64,
   parameter logic [15:0]     INIT_WORD  = 16'h0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  den,
   input  logic                  dwe,
   input  logic [DRP_ADDR_W-1:0] daddr,
   input  logic [DRP_DATA_W-1:0] din,
   output logic [DRP_DATA_W-1:0] dout,
   output logic                  drdy,
   input  logic                  rst_mmcm,
   output logic                  locked,
   output logic                  proto_err
);
   localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
   localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

   drp_state_t                  state;
   logic [3:0]                  lat_cnt;
   logic                        den_q;
   logic                        dwe_l;
   logic [DRP_ADDR_W-1:0]       addr_l;
   logic [DRP_DATA_W-1:0]       rdata;
   logic [DRP_DATA_W-1:0]       regs [2**DRP_ADDR_W];

   logic                        den_rise;
   logic                        accept;
   logic                        held_change;
   logic                        wr_en;
   logic                        lock_viol;
   logic [3:0]                  load;
   logic [DRP_DATA_W-1:0]       rd_word;

   // A new request needs a rising den, so a den held past ACK is never re-accepted.
   assign den_rise    = den & ~den_q;
   assign accept      = (state == IDLE) && den_rise;
   assign held_change = (state == BUSY) && den && den_q && ((dwe != dwe_l) || (daddr != addr_l));
   assign load        = dwe ? WR_LOAD : RD_LOAD;
   assign rd_word     = dwe ? '0 : regs[daddr];

`ifdef MMCM_DRP_WRLOCK_EN
   assign wr_en     = accept && dwe && rst_mmcm;
   assign lock_viol = accept && dwe && !rst_mmcm;
`else
   assign wr_en     = accept && dwe;
   assign lock_viol = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2**DRP_ADDR_W; i++) regs[i] <= INIT_WORD;
      end else if (wr_en) begin
         regs[daddr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         den_q     <= 1'b0;
         dwe_l     <= 1'b0;
         addr_l    <= '0;
         rdata     <= '0;
         dout      <= '0;
         drdy      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         den_q <= den;
         if ((den_rise && (state != IDLE)) || held_change || lock_viol) proto_err <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  dwe_l   <= dwe;
                  addr_l  <= daddr;
                  rdata   <= rd_word;
                  lat_cnt <= load;
                  if (load == 4'd0) begin
                     state <= ACK;
                     drdy  <= 1'b1;
                     dout  <= rd_word;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (lat_cnt == 4'd1) begin
                  state <= ACK;
                  drdy  <= 1'b1;
                  dout  <= rdata;
               end
               lat_cnt <= lat_cnt - 4'd1;
            end
            ACK: begin
               state <= IDLE;
               drdy  <= 1'b0;
               dout  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   mmcm_drp_lock_model #(
      .LOCK_DELAY (LOCK_DELAY)
   ) u_lock (
      .clk      (clk),
      .reset_n  (reset_n),
      .rst_mmcm (rst_mmcm),
      .locked   (locked)
   );
endmodule

`default_nettype wire

// File: tb/tb_mmcm_drp_responder.sv
// tb_mmcm_drp_responder: directed plus randomized DRP traffic checked against an array model. Rev 1.0.
`default_nettype none

module tb_mmcm_drp_responder;
   localparam int RD_LAT   = 3;
   localparam int WR_LAT   = 2;
   localparam int LOCK_DLY = 64;
`ifdef MMCM_DRP_WRLOCK_EN
   localparam bit WRLOCK = 1'b1;
`else
   localparam bit WRLOCK = 1'b0;
`endif

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        den      = 1'b0;
   logic        dwe      = 1'b0;
   logic [6:0]  daddr    = '0;
   logic [15:0] din      = '0;
   logic        rst_mmcm = 1'b1;
   logic [15:0] dout;
   logic        drdy;
   logic        locked;
   logic        proto_err;

   int          checks   = 0;
   int          passed   = 0;
   int          drdy_cnt = 0;
   int          cnt0;
   int          waited;
   logic [15:0] exp_q;
   logic [15:0] model [128];

   mmcm_drp_responder #(
      .RD_LATENCY (RD_LAT),
      .WR_LATENCY (WR_LAT),
      .LOCK_DELAY (LOCK_DLY),
      .INIT_WORD  (16'h0000)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .den       (den),
      .dwe       (dwe),
      .daddr     (daddr),
      .din       (din),
      .dout      (dout),
      .drdy      (drdy),
      .rst_mmcm  (rst_mmcm),
      .locked    (locked),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (drdy) drdy_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // hold: 0 = den pulse, 1 = den held through ACK, 2 = held one cycle past ACK
   task automatic drp_op(input logic we, input logic [6:0] a, input logic [15:0] d,
                         input int hold, input string tag);
      logic [15:0] expd;
      int          lat;
      int          w;
      expd = we ? 16'h0000 : model[a];
      if (we && (!WRLOCK || rst_mmcm)) model[a] = d;
      lat  = we ? WR_LAT : RD_LAT;
      den = 1'b1; dwe = we; daddr = a; din = d;
      tick();
      w = 1;
      if (hold == 0) den = 1'b0;
      while (!drdy && w < 40) begin
         tick();
         w++;
      end
      check({tag, "_lat"}, w, lat);
      check({tag, "_dout"}, dout, expd);
      tick();
      check({tag, "_pulse"}, drdy, 1'b0);
      if (hold == 2) tick();
      den = 1'b0;
      dwe = 1'b0;
      if (hold != 0) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) model[i] = 16'h0000;

      // Reset values
      repeat (3) tick();
      check("rst_drdy", drdy, 1'b0);
      check("rst_dout", dout, 16'h0000);
      check("rst_locked", locked, 1'b0);
      check("rst_perr", proto_err, 1'b0);
      reset_n = 1'b1;
      tick();

      // Basic read, write, read-after-write, neighbours untouched
      drp_op(1'b0, 7'h08, 16'h0000, 0, "rd_after_rst");
      drp_op(1'b1, 7'h28, 16'hA5C3, 0, "wr_power");
      drp_op(1'b0, 7'h28, 16'h0000, 0, "rd_power");
      drp_op(1'b0, 7'h08, 16'h0000, 0, "rd_clkout0_1");
      drp_op(1'b0, 7'h09, 16'h0000, 1, "rd_clkout0_2");

      // Master-style held den: 23 read-modify-write pairs
      cnt0 = drdy_cnt;
      for (int p = 0; p < 23; p++) begin
         logic [6:0]  a;
         logic [15:0] v;
         int          h;
         a = 7'($urandom_range(0, 127));
         h = 1 + $urandom_range(0, 1);
         v = model[a] ^ 16'($urandom);
         drp_op(1'b0, a, 16'h0000, h, "rmw_rd");
         drp_op(1'b1, a, v, h, "rmw_wr");
      end
      check("rmw_drdy_count", drdy_cnt - cnt0, 46);
      check("rmw_perr", proto_err, 1'b0);

      // Random pulsed traffic
      for (int k = 0; k < 12; k++)
         drp_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 16'($urandom), 0, "rand");
      drp_op(1'b0, 7'h28, 16'h0000, 0, "rd_power_final");
      check("rand_perr", proto_err, 1'b0);

      // Lock model: release, then a single-cycle rst_mmcm pulse
      rst_mmcm = 1'b0;
      waited = 0;
      while (!locked && waited < 200) begin
         tick();
         waited++;
      end
      check("lock_delay", waited, LOCK_DLY);
      rst_mmcm = 1'b1;
      tick();
      check("lock_drop", locked, 1'b0);
      rst_mmcm = 1'b0;
      waited = 0;
      while (!locked && waited < 200) begin
         tick();
         waited++;
      end
      check("relock_delay", waited, LOCK_DLY);

      // den rising edge during BUSY: flagged, dropped write, in-flight read unaffected
      exp_q = model[7'h09];
      den = 1'b1; dwe = 1'b0; daddr = 7'h09;
      tick();
      den = 1'b0;
      tick();
      den = 1'b1; dwe = 1'b1; daddr = 7'h16; din = 16'hDEAD;
      tick();
      check("perr_inflight_drdy", drdy, 1'b1);
      check("perr_inflight_dout", dout, exp_q);
      check("perr_set", proto_err, 1'b1);
      den = 1'b0; dwe = 1'b0;
      tick();
      check("perr_drdy_low", drdy, 1'b0);
      drp_op(1'b0, 7'h16, 16'h0000, 0, "dropped_wr");
      check("perr_sticky", proto_err, 1'b1);

      // reset_n asserted while a write is in BUSY
      cnt0 = drdy_cnt;
      den = 1'b1; dwe = 1'b1; daddr = 7'h14; din = 16'h5A5A;
      tick();
      den = 1'b0; dwe = 1'b0;
      reset_n = 1'b0;
      #1;
      check("mid_rst_locked", locked, 1'b0);
      check("mid_rst_perr", proto_err, 1'b0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 128; i++) model[i] = 16'h0000;
      repeat (5) tick();
      check("mid_rst_no_drdy", drdy_cnt - cnt0, 0);
      check("mid_rst_locked_after", locked, 1'b0);
      drp_op(1'b0, 7'h14, 16'h0000, 0, "mid_rst_rd");
      drp_op(1'b0, 7'h28, 16'h0000, 0, "mid_rst_rd_power");

      // Write while rst_mmcm=0: suppressed and flagged only with the write lock enabled
      rst_mmcm = 1'b0;
      drp_op(1'b1, 7'h08, 16'h1234, 0, "wrlock_wr");
      check("wrlock_perr", proto_err, WRLOCK);
      drp_op(1'b0, 7'h08, 16'h0000, 0, "wrlock_rd");
      rst_mmcm = 1'b1;
      drp_op(1'b1, 7'h08, 16'h4321, 0, "wr_in_rst");
      drp_op(1'b0, 7'h08, 16'h0000, 0, "rd_in_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

`default_nettype wire
